// File: rtl/instr_fetch_memory.sv
// Instruction store for a single-cycle core: loads a little-endian byte stream
// into 32-bit words, then serves combinational fetches addressed by the PC.
module instr_fetch_memory #(
  parameter int          DEPTH = 256,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              pc,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     run,
  output logic [31:0]              instruction,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   loaded_words
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_WORDS = LW'(DEPTH);
  localparam logic [LW-1:0] LAST_WORD  = LW'(DEPTH - 1);

  // Loader handshake: a byte moves on any rising edge where load_valid and
  // load_ready are both high; load_last only counts on such an edge.
  typedef enum logic {LOAD, RUN} state_t;

  state_t        state, state_next;
  logic [1:0]    lane;
  logic [AW-1:0] wptr;
  logic [31:0]   staging;
  logic [31:0]   mem [DEPTH];

  logic          xfer;
  logic          commit;
  logic          fill_done;
  logic [31:0]   commit_word;
  logic          fetch_ok;
  logic [AW-1:0] fetch_idx;

  assign load_ready  = (state == LOAD);
  assign run         = (state == RUN);
  assign xfer        = load_valid && load_ready;
  assign commit      = xfer && ((lane == 2'd3) || load_last);
  assign fill_done   = commit && (loaded_words == LAST_WORD);
  // Upper lanes of a short final word stay zero because staging is cleared on commit.
  assign commit_word = staging | ({24'b0, load_byte} << {lane, 3'b000});

  // Full 64-bit range check so high PC bits can never alias into the array.
  assign fetch_ok    = (pc[1:0] == 2'b00) && (pc[63:2] < 62'(DEPTH));
  assign fetch_idx   = pc[AW+1:2];
  assign instruction = (run && fetch_ok) ? mem[fetch_idx] : NOP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD: if ((xfer && load_last) || fill_done) state_next = RUN;
      RUN:  state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane         <= 2'd0;
      wptr         <= '0;
      staging      <= 32'b0;
      loaded_words <= '0;
    end else if (commit) begin
      lane    <= 2'd0;
      wptr    <= wptr + 1'b1;
      staging <= 32'b0;
      if (loaded_words != FULL_WORDS) loaded_words <= loaded_words + 1'b1;
    end else if (xfer) begin
      lane    <= lane + 1'b1;
      staging <= commit_word;
    end
  end

  // The array itself is deliberately not reset; a reload overwrites it.
  always_ff @(posedge clock) begin
    if (commit) mem[wptr] <= commit_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                fault <= 1'b0;
    else if (run && !fetch_ok) fault <= 1'b1;
  end

endmodule

// File: tb/tb_instr_fetch_memory.sv
// Bench for instr_fetch_memory with a 4-word store: directed load/fetch
// sequences, a fetch vector table and randomized programs against a byte model.
module tb_instr_fetch_memory;

  localparam int          DEPTH = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   pc = 64'd0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_byte = 8'd0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          run;
  logic [31:0]   instruction;
  logic          fault;
  logic [LW-1:0] loaded_words;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] exp_q[$];
  logic [7:0]  prog[16];
  logic [31:0] model_w[DEPTH];
  int          len, nwords, kind, idx;
  logic        use_last;
  logic [63:0] probe_pc;
  logic [31:0] probe_exp;
  logic        probe_fault;

  instr_fetch_memory #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .run          (run),
    .instruction  (instruction),
    .fault        (fault),
    .loaded_words (loaded_words)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic do_reset();
    reset      = 1'b1;
    pc         = 64'd0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = 8'd0;
  endtask

  task automatic idle(input int n, input logic junk_last);
    load_valid = 1'b0;
    load_last  = junk_last;
    repeat (n) @(posedge clock);
    #1;
    load_last = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fetch_check(input string name, input logic [63:0] a, input logic [31:0] exp);
    pc = a;
    #1;
    check(name, 64'(instruction), 64'(exp));
  endtask

  initial begin
    vecs[0] = '{pc: 64'd0,             instr: 32'h0403_0201, fault: 1'b0};
    vecs[1] = '{pc: 64'd4,             instr: 32'h0000_0605, fault: 1'b0};
    vecs[2] = '{pc: 64'd2,             instr: NOP,           fault: 1'b1};
    vecs[3] = '{pc: 64'd0,             instr: 32'h0403_0201, fault: 1'b1};
    vecs[4] = '{pc: 64'h1_0000_0000,   instr: NOP,           fault: 1'b1};
    vecs[5] = '{pc: 64'd16,            instr: NOP,           fault: 1'b1};
    vecs[6] = '{pc: 64'd4,             instr: 32'h0000_0605, fault: 1'b1};

    // Reset state
    do_reset();
    check("rst_run", 64'(run), 64'd0);
    check("rst_ready", 64'(load_ready), 64'd1);
    check("rst_instr", 64'(instruction), 64'(NOP));
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_words", 64'(loaded_words), 64'd0);

    // Single word program
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    check("w1_run_early", 64'(run), 64'd0);
    send_byte(8'h00, 1'b1);
    check("w1_run", 64'(run), 64'd1);
    check("w1_ready", 64'(load_ready), 64'd0);
    check("w1_words", 64'(loaded_words), 64'd1);
    fetch_check("w1_instr", 64'd0, 32'h00A0_0513);

    // Six byte program, then the fetch vector table
    do_reset();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    check("w6_words", 64'(loaded_words), 64'd2);
    for (int i = 0; i < 7; i++) begin
      fetch_check($sformatf("vec%0d_instr", i), vecs[i].pc, vecs[i].instr);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_fault", i), 64'(fault), 64'(vecs[i].fault));
    end

    // Memory full without load_last
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_run_early", 64'(run), 64'd0);
      send_byte(8'h10 + 8'(i), 1'b0);
    end
    check("full_run", 64'(run), 64'd1);
    check("full_ready", 64'(load_ready), 64'd0);
    check("full_words", 64'(loaded_words), 64'(DEPTH));
    send_byte(8'hEE, 1'b1);
    check("full_extra_words", 64'(loaded_words), 64'(DEPTH));
    fetch_check("full_w0", 64'd0, 32'h1312_1110);
    fetch_check("full_w3", 64'd12, 32'h1F1E_1D1C);
    @(posedge clock);
    #1;
    check("full_no_fault", 64'(fault), 64'd0);
    fetch_check("full_oob", 64'd16, NOP);
    @(posedge clock);
    #1;
    check("full_oob_fault", 64'(fault), 64'd1);

    // Reset mid-load: partial staging is discarded
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    check("midrst_words", 64'(loaded_words), 64'd0);
    send_byte(8'hAA, 1'b1);
    fetch_check("midrst_short", 64'd0, 32'h0000_00AA);
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    check("midrst_words2", 64'(loaded_words), 64'd1);
    fetch_check("midrst_word", 64'd0, 32'hDDCC_BBAA);

    // Idle cycles carrying a stray load_last; fetches in LOAD never fault
    do_reset();
    pc = 64'd2;
    send_byte(8'h11, 1'b0);
    idle(2, 1'b1);
    check("gap_run", 64'(run), 64'd0);
    check("gap_words", 64'(loaded_words), 64'd0);
    check("gap_instr", 64'(instruction), 64'(NOP));
    check("gap_fault", 64'(fault), 64'd0);
    send_byte(8'h22, 1'b0);
    idle(1, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(3, 1'b1);
    check("gap_run2", 64'(run), 64'd0);
    send_byte(8'h44, 1'b1);
    check("gap_run_end", 64'(run), 64'd1);
    fetch_check("gap_word", 64'd0, 32'h4433_2211);

    // Randomized programs against the byte-stream model
    for (int it = 0; it < 30; it++) begin
      do_reset();
      len      = $urandom_range(1, 16);
      use_last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      nwords = (len + 3) / 4;
      for (int w = 0; w < nwords; w++) begin
        model_w[w] = 32'd0;
        for (int k = 0; k < 4; k++)
          if (4 * w + k < len) model_w[w][8*k +: 8] = prog[4 * w + k];
        exp_q.push_back(model_w[w]);
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        if (i == len - 1) check("rnd_run_early", 64'(run), 64'd0);
        send_byte(prog[i], use_last && (i == len - 1));
      end
      check("rnd_run", 64'(run), 64'd1);
      check("rnd_words", 64'(loaded_words), 64'(nwords));
      for (int w = 0; w < nwords; w++)
        fetch_check($sformatf("rnd_word%0d", w), 64'(4 * w), exp_q.pop_front());

      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, nwords - 1);
      case (kind)
        0: begin probe_pc = 64'(4 * idx); probe_exp = model_w[idx]; probe_fault = 1'b0; end
        1: begin probe_pc = 64'(4 * idx + $urandom_range(1, 3)); probe_exp = NOP; probe_fault = 1'b1; end
        2: begin probe_pc = 64'(4 * $urandom_range(DEPTH, 1000)); probe_exp = NOP; probe_fault = 1'b1; end
        default: begin
          probe_pc = {($urandom | 32'h8000_0000), 32'(4 * idx)};
          probe_exp = NOP;
          probe_fault = 1'b1;
        end
      endcase
      fetch_check("rnd_probe", probe_pc, probe_exp);
      @(posedge clock);
      #1;
      check("rnd_probe_fault", 64'(fault), 64'(probe_fault));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_memory.md
# instr_fetch_memory

Instruction store and fetch stage directly downstream of the program counter. After reset it accepts a program as a little-endian byte stream through a valid/ready loader port and packs it into 32-bit words. It then switches to run mode and returns the instruction addressed by the 64-bit `pc` combinationally, as the single-cycle datapath requires. Misaligned or out-of-range fetches return a NOP and raise a sticky fault.

## Interface
- `DEPTH`, 256: instruction words stored; power of two, 4 to 4096.
- `NOP`, 32'h0000_0013: word returned on faulting fetch (addi x0,x0,0).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `pc`  in  64  byte address from the program counter (`pc_current`).
- `load_valid`  in  1  loader byte is valid.
- `load_byte`  in  8  program byte, little-endian order.
- `load_last`  in  1  qualifies the final byte of the program; sampled with `load_valid`.
- `load_ready`  out  1  block accepts a byte this cycle.
- `run`  out  1  program loaded; the core is held in reset while this is low.
- `instruction`  out  32  fetched instruction.
- `fault`  out  1  sticky: a misaligned or out-of-range fetch occurred in RUN.
- `loaded_words`  out  clog2(DEPTH)+1  count of words committed during load.

## Operation
- States: LOAD (reset state), RUN. No other states.
- A transfer occurs on a clock edge where `load_valid && load_ready`.
- In LOAD, `load_ready` = 1. In RUN, `load_ready` = 0.
- In LOAD, a 2-bit byte lane counter `lane` and a word pointer `wptr` are used. Each transfer places `load_byte` into bits [8*lane+7 : 8*lane] of a staging register, then increments `lane`.
- Word commit happens when the transfer has `lane` = 3, or when `load_last` = 1 is accepted at any lane:
  - The staging word is written to mem[`wptr`]. Unfilled upper lanes are zero-filled.
  - `wptr` and `loaded_words` increment. `lane` and the staging register clear.
- Transition LOAD -> RUN occurs on the edge of:
  - an accepted `load_last`, or
  - the commit that makes `loaded_words` = DEPTH (memory full). In that case `load_last` is not required.
- RUN is left only by `reset`.
- RUN fetch:
  - A fetch is valid when `pc[1:0]` = 0 and `pc[63:2]` < DEPTH. Then `instruction` = mem[`pc[clog2(DEPTH)+1:2]`].
  - Otherwise `instruction` = NOP, and `fault` sets on the next edge.
  - Words at index >= `loaded_words` return current array contents. Out-of-range checks use DEPTH, not `loaded_words`.
- In LOAD, `instruction` = NOP and `fault` is not updated.
- Width rules:
  - `pc` is compared with the full 64-bit width, so high address bits never alias.
  - `loaded_words` saturates at DEPTH.

## Timing
- Reset values: `run` = 0, `load_ready` = 1, `instruction` = NOP, `fault` = 0, `loaded_words` = 0. Internal `lane` = 0, `wptr` = 0, staging = 0, state = LOAD.
- The memory array is not cleared by reset.
- Write latency: a committed word is readable in RUN from the cycle after its commit edge.
- `run` rises in the cycle after the final accepted byte. `load_ready` falls in the same cycle.
- `instruction` is combinational from `pc` and state, with zero-cycle read latency.
- `fault` registers one edge after the faulting fetch and holds until reset.
- Reset mid-load: any partial staging word is discarded, pointers return to 0, and loading restarts. Previously committed words stay in the array until overwritten.
- A byte with `load_valid` = 0 is ignored, including its `load_last`.

## Test plan
- Load bytes 13,05,A0,00 with `last` on the 4th byte. Expect mem[0] = 32'h00A00513, `loaded_words` = 1, and `run` = 1 the next cycle. With `pc` = 0, expect `instruction` = 32'h00A00513.
- Load 6 bytes 01..06 with `last` on byte 6. Expect mem[0] = 32'h04030201, mem[1] = 32'h00000605, and `loaded_words` = 2.
- DEPTH = 4: stream 16 bytes with no `last`. Expect `run` = 1 after byte 16, `load_ready` = 0, and a 17th byte ignored.
- In RUN, apply `pc` = 2. Expect `instruction` = 32'h00000013 and `fault` = 1 one edge later, still 1 after `pc` returns to 0. Apply `pc` = 64'h1_0000_0000. Expect NOP.
- Assert `reset` after 3 bytes, then load 4 bytes AA,BB,CC,DD with `last`. Expect mem[0] = 32'hDDCCBBAA and `loaded_words` = 1.
- Toggle `load_valid` low between bytes, with `load_last` = 1 while `load_valid` = 0. Expect no state change and no premature `run`.
